// File: rtl/aq_reduce_pkg.sv
// aq_reduce_pkg: shared types for the AXI4-Stream nearest-neighbour downscaler.
//   ACC_W     - DDA accumulator width (16-bit sizes plus one carry bit)
//   cfg_t     - per-frame geometry (source size, target size)
//   is_bypass - a frame passes through untouched when its geometry cannot be reduced
package aq_reduce_pkg;

  localparam int ACC_W = 17;

  typedef logic [ACC_W-1:0] acc_t;

  typedef struct packed {
    logic [15:0] org_x;
    logic [15:0] org_y;
    logic [15:0] cnv_x;
    logic [15:0] cnv_y;
  } cfg_t;

  // Zero sizes or upscaling requests are not handled by the DDA; pass through.
  function automatic logic is_bypass(input cfg_t c);
    return (c.org_x == 16'd0) || (c.org_y == 16'd0) ||
           (c.cnv_x == 16'd0) || (c.cnv_y == 16'd0) ||
           (c.cnv_x > c.org_x) || (c.cnv_y > c.org_y);
  endfunction

endpackage

// File: rtl/aq_axis_skid.sv
// aq_axis_skid: 2-entry AXI4-Stream skid buffer with a registered ready.
//   clk, rst_n            clock, async active-low reset
//   s_data/s_valid/s_ready upstream side; s_ready is a flop meaning "skid slot empty"
//   m_data/m_valid/m_ready downstream side, driven straight from the output register
module aq_axis_skid #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready
);

  logic [W-1:0] out_q, out_d, skd_q, skd_d;
  logic         out_vld_q, out_vld_d, skd_vld_q, skd_vld_d;
  logic         rdy_q, rdy_d;
  logic         push;

  always_comb begin
    push      = s_valid & rdy_q;
    out_d     = out_q;
    out_vld_d = out_vld_q;
    skd_d     = skd_q;
    skd_vld_d = skd_vld_q;
    if (!out_vld_q || m_ready) begin
      // Output slot frees this cycle: drain the skid first to keep order.
      // rdy_q is low whenever the skid holds a beat, so no push can collide.
      if (skd_vld_q) begin
        out_d     = skd_q;
        out_vld_d = 1'b1;
        skd_vld_d = 1'b0;
      end else begin
        out_vld_d = push;
        if (push) out_d = s_data;
      end
    end else if (push) begin
      // Output stalled: the beat already in flight parks in the skid.
      skd_d     = s_data;
      skd_vld_d = 1'b1;
    end
    rdy_d = ~skd_vld_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q     <= '0;
      out_vld_q <= 1'b0;
      skd_q     <= '0;
      skd_vld_q <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
      skd_q     <= skd_d;
      skd_vld_q <= skd_vld_d;
      rdy_q     <= rdy_d;
    end
  end

  assign s_ready = rdy_q;
  assign m_data  = out_q;
  assign m_valid = out_vld_q;

endmodule

// File: rtl/aq_axis_reduce_core.sv
// aq_axis_reduce_core: nearest-neighbour video downscaler on AXI4-Stream.
//   ACLK, ARESETN              clock, async active-low reset
//   ORG_X/ORG_Y, CNV_X/CNV_Y   source / target geometry, latched on each accepted SOF
//   S_AXIS_*                   input pixels (TUSER = SOF, TLAST = end of line)
//   M_AXIS_*                   decimated pixels, one cycle after acceptance
// Column and row DDAs decide keep/drop per pixel and per line; kept pixels are
// pushed into a skid buffer that provides the registered S_AXIS_TREADY.
module aq_axis_reduce_core #(
  parameter int DATA_W = 24
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic [15:0]       ORG_X,
  input  logic [15:0]       ORG_Y,
  input  logic [15:0]       CNV_X,
  input  logic [15:0]       CNV_Y,
  input  logic [DATA_W-1:0] S_AXIS_TDATA,
  input  logic              S_AXIS_TUSER,
  input  logic              S_AXIS_TLAST,
  input  logic              S_AXIS_TVALID,
  output logic              S_AXIS_TREADY,
  output logic [DATA_W-1:0] M_AXIS_TDATA,
  output logic              M_AXIS_TUSER,
  output logic              M_AXIS_TLAST,
  output logic              M_AXIS_TVALID,
  input  logic              M_AXIS_TREADY
);

  import aq_reduce_pkg::*;

  localparam int PW = DATA_W + 2;

  cfg_t          cfg_q, cfg_d, cfg_in, cfg_eff;
  acc_t          acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  acc_t          acc_x_eff, acc_y_eff, tx, ty, org_x_w, org_y_w;
  logic          line_keep_q, line_keep_d, line_keep_eff;
  logic          first_q, first_d, is_first;
  logic          sof_pend_q, sof_pend_d, sof_pend_eff;
  logic          active_q, active_d, active_eff;
  logic          accept, bypass, keep_px, emit, s_ready;
  logic [PW-1:0] push_data, m_data;

  assign cfg_in = '{org_x: ORG_X, org_y: ORG_Y, cnv_x: CNV_X, cnv_y: CNV_Y};

  always_comb begin
    accept = S_AXIS_TVALID & s_ready;
    // The SOF beat itself already uses the geometry being latched with it.
    cfg_eff  = S_AXIS_TUSER ? cfg_in : cfg_q;
    bypass   = is_bypass(cfg_eff);
    is_first = S_AXIS_TUSER | first_q;
    org_x_w  = {1'b0, cfg_eff.org_x};
    org_y_w  = {1'b0, cfg_eff.org_y};

    acc_y_eff = S_AXIS_TUSER ? '0 : acc_y_q;
    acc_x_eff = is_first ? '0 : acc_x_q;
    ty        = acc_y_eff + {1'b0, cfg_eff.cnv_y};
    tx        = acc_x_eff + {1'b0, cfg_eff.cnv_x};

    line_keep_eff = is_first ? (ty >= org_y_w) : line_keep_q;
    keep_px       = (tx >= org_x_w);
    // Nothing is emitted until an SOF has been seen since reset.
    active_eff    = active_q | S_AXIS_TUSER;
    sof_pend_eff  = sof_pend_q | S_AXIS_TUSER;
    // Line end of a kept line is always emitted so every output line terminates.
    emit = accept & active_eff &
           (bypass | (line_keep_eff & (keep_px | S_AXIS_TLAST)));

    cfg_d       = cfg_q;
    acc_x_d     = acc_x_q;
    acc_y_d     = acc_y_q;
    line_keep_d = line_keep_q;
    first_d     = first_q;
    sof_pend_d  = sof_pend_q;
    active_d    = active_q;
    if (accept) begin
      if (S_AXIS_TUSER) cfg_d = cfg_in;
      active_d    = active_eff;
      first_d     = S_AXIS_TLAST;
      line_keep_d = line_keep_eff;
      if (S_AXIS_TLAST)       acc_x_d = '0;
      else if (line_keep_eff) acc_x_d = keep_px ? (tx - org_x_w) : tx;
      else                    acc_x_d = acc_x_eff;
      if (S_AXIS_TLAST) acc_y_d = (ty >= org_y_w) ? (ty - org_y_w) : ty;
      else              acc_y_d = acc_y_eff;
      sof_pend_d = sof_pend_eff & ~emit;
    end

    push_data = {S_AXIS_TDATA, sof_pend_eff, S_AXIS_TLAST};
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      cfg_q       <= '0;
      acc_x_q     <= '0;
      acc_y_q     <= '0;
      line_keep_q <= 1'b0;
      first_q     <= 1'b0;
      sof_pend_q  <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      cfg_q       <= cfg_d;
      acc_x_q     <= acc_x_d;
      acc_y_q     <= acc_y_d;
      line_keep_q <= line_keep_d;
      first_q     <= first_d;
      sof_pend_q  <= sof_pend_d;
      active_q    <= active_d;
    end
  end

  aq_axis_skid #(.W(PW)) u_skid (
    .clk     (ACLK),
    .rst_n   (ARESETN),
    .s_data  (push_data),
    .s_valid (emit),
    .s_ready (s_ready),
    .m_data  (m_data),
    .m_valid (M_AXIS_TVALID),
    .m_ready (M_AXIS_TREADY)
  );

  assign S_AXIS_TREADY = s_ready;
  assign M_AXIS_TDATA  = m_data[PW-1:2];
  assign M_AXIS_TUSER  = m_data[1];
  assign M_AXIS_TLAST  = m_data[0];

endmodule
